// File: rtl/audio_pkg.sv
// Shared types and sizing helpers for the audio mix path.
// The accumulator width lives here so the engine and any future user agree on it.
package audio_pkg;

  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_SAMPLE_W     = 16;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_VOL_W        = 8;
  localparam int GAIN_UNITY       = 1 << (DEF_VOL_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ADDR,
    ST_DATA,
    ST_MAC,
    ST_DONE
  } mix_state_t;

  // One sign bit plus headroom for summing every channel at full gain.
  function automatic int acc_width(input int sample_w, input int vol_w, input int num_ch);
    return sample_w + vol_w + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/audio_saturate.sv
// Arithmetic right shift followed by a clamp to the signed output range.
// Used once per stereo side to turn the wide accumulator into a sample.
module audio_saturate #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] sat
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  assign shifted = acc >>> SHIFT;

  always_comb begin
    sat = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      sat = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      sat = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/audio_mix_engine.sv
// Per-tick channel walker: fetches one sample per active channel over AXI-Lite,
// applies left/right gain, accumulates, and emits one saturated stereo frame.
module audio_mix_engine
  import audio_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int SAMPLE_W     = DEF_SAMPLE_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int VOL_W        = DEF_VOL_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_tick,
  input  logic [NUM_CHANNELS-1:0]        ch_active,
  input  logic [NUM_CHANNELS*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CHANNELS*VOL_W-1:0]  ch_vol_l,
  input  logic [NUM_CHANNELS*VOL_W-1:0]  ch_vol_r,
  output logic [NUM_CHANNELS-1:0]        ch_advance,
  output logic [ADDR_W-1:0]              m_axil_araddr,
  output logic [2:0]                     m_axil_arprot,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready,
  input  logic [SAMPLE_W-1:0]            m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready,
  output logic signed [SAMPLE_W-1:0]     mix_left,
  output logic signed [SAMPLE_W-1:0]     mix_right,
  output logic                           mix_valid,
  output logic                           busy,
  output logic                           overrun,
  output logic                           rd_error,
  input  logic                           err_clr,
  output mix_state_t                     dbg_state
);

  localparam int ACC_W = acc_width(SAMPLE_W, VOL_W, NUM_CHANNELS);
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  mix_state_t                 state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic                       idx_last;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic signed [ACC_W-1:0]    acc_l, acc_r;
  logic signed [ACC_W-1:0]    samp_ext, vol_l_ext, vol_r_ext, prod_l, prod_r;
  logic signed [SAMPLE_W-1:0] sat_l, sat_r;

  // Handshakes: a transfer happens on the edge where valid and ready are both high.
  // arvalid is high for the whole ADDR state with araddr frozen, so it never drops
  // before arready; rready is high only in DATA, so at most one read is outstanding.
  assign m_axil_arvalid = (state == ST_ADDR);
  assign m_axil_rready  = (state == ST_DATA);
  assign m_axil_arprot  = 3'b000;
  assign busy           = (state != ST_IDLE);
  assign ch_advance     = (state == ST_MAC) ? (NUM_CHANNELS'(1) << idx) : '0;
  assign dbg_state      = state;
  assign idx_last       = (idx == LAST_IDX);

  // Sign-extend the sample and zero-extend the gain so the product is exact.
  assign samp_ext  = {{(ACC_W-SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q};
  assign vol_l_ext = ACC_W'(ch_vol_l[idx*VOL_W +: VOL_W]);
  assign vol_r_ext = ACC_W'(ch_vol_r[idx*VOL_W +: VOL_W]);
  assign prod_l    = samp_ext * vol_l_ext;
  assign prod_r    = samp_ext * vol_r_ext;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sample_tick) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (ch_active[idx])  state_nxt = ST_ADDR;
        else if (idx_last)   state_nxt = ST_DONE;
      end
      ST_ADDR: if (m_axil_arready) state_nxt = ST_DATA;
      ST_DATA: if (m_axil_rvalid)  state_nxt = ST_MAC;
      ST_MAC:  state_nxt = idx_last ? ST_DONE : ST_SCAN;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      sample_q      <= '0;
      acc_l         <= '0;
      acc_r         <= '0;
      m_axil_araddr <= '0;
      mix_left      <= '0;
      mix_right     <= '0;
      mix_valid     <= 1'b0;
      overrun       <= 1'b0;
      rd_error      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mix_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            acc_l <= '0;
            acc_r <= '0;
            idx   <= '0;
          end
        end
        ST_SCAN: begin
          if (ch_active[idx])  m_axil_araddr <= ch_addr[idx*ADDR_W +: ADDR_W];
          else if (!idx_last)  idx <= idx + 1'b1;
        end
        ST_DATA: begin
          // A failed read contributes silence so the channel is simply skipped.
          if (m_axil_rvalid) sample_q <= (m_axil_rresp == 2'b00) ? m_axil_rdata : '0;
        end
        ST_MAC: begin
          acc_l <= acc_l + prod_l;
          acc_r <= acc_r + prod_r;
          if (!idx_last) idx <= idx + 1'b1;
        end
        ST_DONE: begin
          mix_left  <= sat_l;
          mix_right <= sat_r;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
      if (err_clr) begin
        overrun  <= 1'b0;
        rd_error <= 1'b0;
      end
      if (sample_tick && (state != ST_IDLE)) overrun <= 1'b1;
      if ((state == ST_DATA) && m_axil_rvalid && (m_axil_rresp != 2'b00)) rd_error <= 1'b1;
    end
  end

  audio_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_W), .SHIFT(VOL_W - 1)) u_sat_l (
    .acc (acc_l),
    .sat (sat_l)
  );

  audio_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_W), .SHIFT(VOL_W - 1)) u_sat_r (
    .acc (acc_r),
    .sat (sat_r)
  );

endmodule

// File: tb/tb_audio_mix_engine.sv
// Bench for audio_mix_engine: directed vector table, hand-written corner sequences,
// and randomized frames checked against an arithmetic mixing model.
module tb_audio_mix_engine;
  import audio_pkg::*;

  localparam int N  = 8;
  localparam int SW = 16;
  localparam int AW = 32;
  localparam int VW = 8;
  localparam int BUDGET = 1000;

  logic                 clk, rst, sample_tick, err_clr;
  logic [N-1:0]         ch_active, ch_advance;
  logic [N*AW-1:0]      ch_addr;
  logic [N*VW-1:0]      ch_vol_l, ch_vol_r;
  logic [AW-1:0]        araddr;
  logic [2:0]           arprot;
  logic                 arvalid, arready;
  logic [SW-1:0]        rdata;
  logic [1:0]           rresp;
  logic                 rvalid, rready;
  logic signed [SW-1:0] mix_left, mix_right;
  logic                 mix_valid, busy, overrun, rd_error;
  mix_state_t           dbg_state;

  int checks;
  int errors;

  // Stimulus configuration and memory image served by the AXI responder
  logic [N-1:0] act_v;
  int           vl[N];
  int           vr[N];
  int           sample_mem[N];
  logic [1:0]   resp_mem[N];
  logic [AW-1:0] base;
  int           ar_dly, r_dly;
  int           adv_cnt[N];

  typedef struct {
    logic [7:0] act;
    int         vl;
    int         vr;
    int         smp;
    logic [7:0] err;
    int         ar_d;
    int         r_d;
    int         el;
    int         er;
    int         elat;
  } vec_t;

  vec_t vecs[7];

  audio_mix_engine dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick    (sample_tick),
    .ch_active      (ch_active),
    .ch_addr        (ch_addr),
    .ch_vol_l       (ch_vol_l),
    .ch_vol_r       (ch_vol_r),
    .ch_advance     (ch_advance),
    .m_axil_araddr  (araddr),
    .m_axil_arprot  (arprot),
    .m_axil_arvalid (arvalid),
    .m_axil_arready (arready),
    .m_axil_rdata   (rdata),
    .m_axil_rresp   (rresp),
    .m_axil_rvalid  (rvalid),
    .m_axil_rready  (rready),
    .mix_left       (mix_left),
    .mix_right      (mix_right),
    .mix_valid      (mix_valid),
    .busy           (busy),
    .overrun        (overrun),
    .rd_error       (rd_error),
    .err_clr        (err_clr),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // AXI-Lite responder with programmable AR/R wait states; acts on falling edges
  bit            r_pend, ar_seen;
  int            ar_cnt, r_cnt, r_ch;
  logic [AW-1:0] ar_first, off;

  initial begin : axi_slave
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    r_pend = 0; ar_seen = 0; ar_cnt = 0; r_cnt = 0; r_ch = 0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        arready = 1'b0; rvalid = 1'b0; r_pend = 0; ar_seen = 0;
      end else begin
        arready = 1'b0;
        rvalid  = 1'b0;
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1'b1;
            rdata  = SW'(sample_mem[r_ch]);
            rresp  = resp_mem[r_ch];
            r_pend = 0;
          end else begin
            r_cnt++;
          end
        end
        if (arvalid) begin
          if (!ar_seen) begin
            ar_seen = 1; ar_first = araddr; ar_cnt = 0;
          end else begin
            check("araddr_stable", araddr, ar_first);
          end
          if (ar_cnt >= ar_dly) begin
            arready = 1'b1;
            ar_seen = 0;
            off = araddr - base;
            check("araddr_range", longint'(off[0] == 1'b0 && off < AW'(2 * N)), 1);
            r_ch   = (off[0] == 1'b0 && off < AW'(2 * N)) ? int'(off >> 1) : 0;
            r_pend = 1;
            r_cnt  = 0;
          end else begin
            ar_cnt++;
          end
        end
      end
    end
  end

  initial begin : adv_monitor
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ch_advance[i]) adv_cnt[i]++;
    end
  end

  // Behavioural reference: exact sums, floor division by unity gain, clamp
  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model(input int ar_d, input int r_d, output int el, output int er, output int elat);
    longint al, ar, s;
    int a;
    al = 0; ar = 0; a = 0;
    for (int i = 0; i < N; i++) begin
      if (act_v[i]) begin
        a++;
        s = (resp_mem[i] == 2'b00) ? longint'(sample_mem[i]) : 0;
        al += s * vl[i];
        ar += s * vr[i];
      end
    end
    el   = clamp16(fdiv(al, GAIN_UNITY));
    er   = clamp16(fdiv(ar, GAIN_UNITY));
    elat = 2 + N + a * (3 + ar_d + r_d);
  endtask

  // Driver tasks
  task automatic apply_cfg();
    for (int i = 0; i < N; i++) begin
      ch_active[i]           = act_v[i];
      ch_vol_l[i*VW +: VW]   = VW'(vl[i]);
      ch_vol_r[i*VW +: VW]   = VW'(vr[i]);
      ch_addr[i*AW +: AW]    = base + AW'(i * 2);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic check_reset(input string name);
    check({name, "_araddr"}, araddr, 0);
    check({name, "_ctl"}, {arvalid, rready, mix_left, mix_right, mix_valid, ch_advance,
                           busy, overrun, rd_error}, 0);
  endtask

  // Ticks in the current cycle, optionally injects a tick (and err_clr) mid-frame,
  // and returns on the falling edge where mix_valid is seen.
  task automatic run_frame(input string name, input int ar_d, input int r_d, input int mid_tick,
                           input bit mid_clr, input int el, input int er, input int elat);
    int lat;
    ar_dly = ar_d;
    r_dly  = r_d;
    for (int i = 0; i < N; i++) adv_cnt[i] = 0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    lat = 1;
    while (!mix_valid && lat < BUDGET) begin
      if (lat == mid_tick) begin
        sample_tick = 1'b1;
        err_clr     = mid_clr;
      end
      @(negedge clk);
      sample_tick = 1'b0;
      err_clr     = 1'b0;
      lat++;
    end
    check({name, "_latency"}, lat, elat);
    check({name, "_left"}, mix_left, el);
    check({name, "_right"}, mix_right, er);
    check({name, "_idle"}, busy, 0);
    for (int i = 0; i < N; i++) check($sformatf("%s_advance%0d", name, i), adv_cnt[i], act_v[i]);
  endtask

  task automatic set_uniform(input logic [7:0] act, input int v_l, input int v_r, input int smp,
                             input logic [7:0] err);
    for (int i = 0; i < N; i++) begin
      act_v[i]      = act[i];
      vl[i]         = v_l;
      vr[i]         = v_r;
      sample_mem[i] = smp;
      resp_mem[i]   = err[i] ? 2'b10 : 2'b00;
    end
    apply_cfg();
  endtask

  initial begin : main
    int el, er, elat, ar_d, r_d, amp;
    bit exp_err;
    checks = 0; errors = 0;
    rst = 1'b1; sample_tick = 1'b0; err_clr = 1'b0;
    base = 32'h0004_0000; ar_dly = 0; r_dly = 0;
    for (int i = 0; i < N; i++) adv_cnt[i] = 0;
    set_uniform(8'h00, 0, 0, 0, 8'h00);

    vecs[0] = '{8'hFF, 128, 128,   1000, 8'h00, 0, 0,   8000,   8000, 34};
    vecs[1] = '{8'hFF, 255, 255,  32767, 8'h00, 0, 0,  32767,  32767, 34};
    vecs[2] = '{8'hFF, 255, 255, -32768, 8'h00, 0, 0, -32768, -32768, 34};
    vecs[3] = '{8'h01, 128,   0,   4660, 8'h00, 0, 0,   4660,      0, 13};
    vecs[4] = '{8'h00, 128, 128,   1000, 8'h00, 0, 0,      0,      0, 10};
    vecs[5] = '{8'h01, 128,   0,   4660, 8'h00, 3, 2,   4660,      0, 18};
    vecs[6] = '{8'hFF, 128, 128,   1000, 8'h08, 0, 0,   7000,   7000, 34};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      set_uniform(vecs[v].act, vecs[v].vl, vecs[v].vr, vecs[v].smp, vecs[v].err);
      pulse_clr();
      @(negedge clk);
      run_frame($sformatf("vec%0d", v), vecs[v].ar_d, vecs[v].r_d, 0, 1'b0,
                vecs[v].el, vecs[v].er, vecs[v].elat);
      check($sformatf("vec%0d_rd_error", v), rd_error, longint'(|(vecs[v].err & vecs[v].act)));
      check($sformatf("vec%0d_overrun", v), overrun, 0);
    end
    pulse_clr();
    check("err_clr_rd_error", rd_error, 0);

    // Tick while busy: flagged, frame untouched; set beats a same-cycle clear
    set_uniform(8'hFF, 128, 128, 1000, 8'h00);
    @(negedge clk);
    run_frame("ovr", 0, 0, 5, 1'b0, 8000, 8000, 34);
    check("ovr_flag", overrun, 1);
    pulse_clr();
    check("ovr_cleared", overrun, 0);
    @(negedge clk);
    run_frame("ovr_clr", 0, 0, 9, 1'b1, 8000, 8000, 34);
    check("ovr_set_wins", overrun, 1);
    pulse_clr();
    @(negedge clk);

    // Tick coincident with mix_valid starts the next frame cleanly
    run_frame("chain_a", 0, 0, 0, 1'b0, 8000, 8000, 34);
    run_frame("chain_b", 0, 0, 0, 1'b0, 8000, 8000, 34);
    check("chain_overrun", overrun, 0);

    // Reset during an AXI fetch, then a clean frame
    set_uniform(8'hFF, 128, 128, 1000, 8'h00);
    ar_dly = 1; r_dly = 1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    run_frame("after_rst", 0, 0, 0, 1'b0, 8000, 8000, 34);

    // Randomized frames against the reference model
    for (int f = 0; f < 12; f++) begin
      base    = $urandom() & 32'hFFFF_F000;
      exp_err = 0;
      for (int i = 0; i < N; i++) begin
        amp           = ($urandom_range(0, 1) == 1) ? 32767 : 3000;
        act_v[i]      = 1'($urandom_range(0, 1));
        vl[i]         = int'($urandom_range(0, 255));
        vr[i]         = int'($urandom_range(0, 255));
        sample_mem[i] = int'($urandom_range(0, 2 * amp)) - amp;
        resp_mem[i]   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (act_v[i] && resp_mem[i] != 2'b00) exp_err = 1;
      end
      ar_d = int'($urandom_range(0, 2));
      r_d  = int'($urandom_range(0, 2));
      apply_cfg();
      model(ar_d, r_d, el, er, elat);
      pulse_clr();
      @(negedge clk);
      run_frame($sformatf("rnd%0d", f), ar_d, r_d, 0, 1'b0, el, er, elat);
      check($sformatf("rnd%0d_rd_error", f), rd_error, longint'(exp_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
